// File: rtl/coor_trans_inverse_scan_pkg.sv
// -----------------------------------------------------------------------------
// coor_trans_pkg
//
// Shared definitions for the inverse-mapping rotation scan:
//   - state_e   : scan FSM states
//   - FRAC_BITS : fractional bits of the sin/cos values (Q1.8)
//   - ACC_W     : width of the signed source-coordinate accumulators
//   - TRIG_W    : width of the signed sin/cos inputs
//   - COORD_W   : width of the unsigned destination counters
//   - sext_trig : sign-extends a sin/cos value to accumulator width
// -----------------------------------------------------------------------------
package coor_trans_pkg;

    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 32;
    localparam int TRIG_W    = 10;
    localparam int COORD_W   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_INIT = 2'd1,
        SCAN     = 2'd2,
        DONE     = 2'd3
    } state_e;

    function automatic logic signed [ACC_W-1:0] sext_trig(input logic signed [TRIG_W-1:0] v);
        return {{(ACC_W-TRIG_W){v[TRIG_W-1]}}, v};
    endfunction

endpackage

// File: rtl/coor_trans_inverse_scan_if.sv
// -----------------------------------------------------------------------------
// coor_trans_inverse_scan_if
//
// Valid/ready coordinate stream from the inverse scan to a frame-buffer reader.
//   out_valid / out_ready : beat handshake
//   dst_x / dst_y         : destination pixel (unsigned)
//   src_x / src_y         : source pixel, signed integer (floor)
//   in_range              : source pixel lies inside the frame
//   sof / eol / eof       : first of frame / last of row / last of frame
// master = coordinate generator, slave = consumer.
// -----------------------------------------------------------------------------
interface coor_trans_inverse_scan_if;
    import coor_trans_pkg::*;

    logic                      out_valid;
    logic                      out_ready;
    logic [COORD_W-1:0]        dst_x;
    logic [COORD_W-1:0]        dst_y;
    logic signed [ACC_W-1:0]   src_x;
    logic signed [ACC_W-1:0]   src_y;
    logic                      in_range;
    logic                      sof;
    logic                      eol;
    logic                      eof;

    modport master (
        output out_valid, dst_x, dst_y, src_x, src_y, in_range, sof, eol, eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, dst_x, dst_y, src_x, src_y, in_range, sof, eol, eof,
        output out_ready
    );

endinterface

// File: rtl/coor_trans_inverse_scan_rot_acc.sv
// -----------------------------------------------------------------------------
// coor_rot_acc
//
// Holds the two Q.8 source accumulators of the inverse rotation and turns them
// into integer source coordinates.
//   clk, rst         : clock, synchronous active-high reset
//   load             : reload both accumulators for column 0 of row yc
//   step             : advance both accumulators by one destination column
//   yc               : destination row relative to the image centre
//   sin_lat, cos_lat : latched sin/cos for the frame (Q1.8)
//   src_x, src_y     : floor source coordinates (offset back to image origin)
//   in_range         : source coordinate lies inside the frame
//
// Both axes share one form: acc = xc*k_xc + yc*k_yc, with
//   x axis: k_xc =  cos, k_yc = sin
//   y axis: k_xc = -sin, k_yc = cos
// so a load uses xc = -W/2 and each column step adds k_xc. The step is an exact
// integer add of the same term the multiply would produce, so there is no drift.
// -----------------------------------------------------------------------------
module coor_rot_acc
    import coor_trans_pkg::*;
#(
    parameter int IMAGE_W = 1024,
    parameter int IMAGE_H = 768
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic signed [ACC_W-1:0]   yc,
    input  logic signed [TRIG_W-1:0]  sin_lat,
    input  logic signed [TRIG_W-1:0]  cos_lat,
    output logic signed [ACC_W-1:0]   src_x,
    output logic signed [ACC_W-1:0]   src_y,
    output logic                      in_range
);

    localparam logic signed [ACC_W-1:0] NEG_HALF_W = -(IMAGE_W / 2);

    logic signed [ACC_W-1:0] sin_ext;
    logic signed [ACC_W-1:0] cos_ext;
    logic signed [ACC_W-1:0] src_axis [2];
    logic [1:0]              axis_ok;

    assign sin_ext = sext_trig(sin_lat);
    assign cos_ext = sext_trig(cos_lat);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            localparam int HALF = (gi == 0) ? (IMAGE_W / 2) : (IMAGE_H / 2);
            localparam int DIM  = (gi == 0) ? IMAGE_W : IMAGE_H;
            localparam logic signed [ACC_W-1:0] HALF_S = HALF;
            localparam logic signed [ACC_W-1:0] DIM_S  = DIM;

            logic signed [ACC_W-1:0] k_xc;
            logic signed [ACC_W-1:0] k_yc;
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] acc_next;
            logic signed [ACC_W-1:0] src;

            if (gi == 0) begin : g_x
                assign k_xc = cos_ext;
                assign k_yc = sin_ext;
            end else begin : g_y
                assign k_xc = -sin_ext;
                assign k_yc = cos_ext;
            end

            always_comb begin
                acc_next = acc_reg;
                if (load) begin
                    acc_next = NEG_HALF_W * k_xc + yc * k_yc;
                end else if (step) begin
                    acc_next = acc_reg + k_xc;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end

            // Arithmetic shift floors toward -inf, matching the integer pixel grid.
            assign src           = (acc_reg >>> FRAC_BITS) + HALF_S;
            assign src_axis[gi]  = src;
            assign axis_ok[gi]   = !src[ACC_W-1] && (src < DIM_S);
        end
    endgenerate

    assign src_x    = src_axis[0];
    assign src_y    = src_axis[1];
    assign in_range = &axis_ok;

endmodule

// File: rtl/coor_trans_inverse_scan.sv
// -----------------------------------------------------------------------------
// coor_trans_inverse_scan
//
// Inverse-mapping address generator for image rotation. Walks every destination
// pixel in raster order and emits the source pixel that rotates onto it using
// R(-theta) about the image centre.
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle frame start, ignored while busy
//   sin_value, cos_value : Q1.8 signed sin/cos, latched on an accepted start
//   busy                 : frame in progress (ROW_INIT, SCAN, DONE)
//   done                 : one-cycle pulse after the final beat is accepted
//   bus                  : coordinate stream (master side)
//
// Each row spends one ROW_INIT cycle reloading the accumulators by multiply,
// then W SCAN beats that step the accumulators on every handshake. Counters and
// accumulators only move on a handshake, so outputs hold while stalled.
// -----------------------------------------------------------------------------
module coor_trans_inverse_scan
    import coor_trans_pkg::*;
#(
    parameter int IMAGE_W = 1024,
    parameter int IMAGE_H = 768
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [TRIG_W-1:0]  sin_value,
    input  logic signed [TRIG_W-1:0]  cos_value,
    output logic                      busy,
    output logic                      done,
    coor_trans_inverse_scan_if.master bus
);

    localparam logic [COORD_W-1:0]      LAST_X = COORD_W'(IMAGE_W - 1);
    localparam logic [COORD_W-1:0]      LAST_Y = COORD_W'(IMAGE_H - 1);
    localparam logic signed [ACC_W-1:0] HALF_H = IMAGE_H / 2;

    state_e                     state_reg, state_next;
    logic [COORD_W-1:0]         dst_x_reg, dst_x_next;
    logic [COORD_W-1:0]         dst_y_reg, dst_y_next;
    logic signed [TRIG_W-1:0]   sin_reg, sin_next;
    logic signed [TRIG_W-1:0]   cos_reg, cos_next;

    logic                       out_valid;
    logic                       handshake;
    logic                       acc_load;
    logic                       acc_step;
    logic signed [ACC_W-1:0]    yc;
    logic signed [ACC_W-1:0]    src_x_raw;
    logic signed [ACC_W-1:0]    src_y_raw;
    logic                       in_range_raw;

    assign out_valid = (state_reg == SCAN);
    assign handshake = out_valid && bus.out_ready;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == DONE);

    assign yc = $signed({{(ACC_W-COORD_W){1'b0}}, dst_y_reg}) - HALF_H;

    always_comb begin
        state_next = state_reg;
        dst_x_next = dst_x_reg;
        dst_y_next = dst_y_reg;
        sin_next   = sin_reg;
        cos_next   = cos_reg;
        acc_load   = 1'b0;
        acc_step   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    sin_next   = sin_value;
                    cos_next   = cos_value;
                    dst_y_next = '0;
                    state_next = ROW_INIT;
                end
            end
            ROW_INIT: begin
                // dst_y is already the new row, so yc feeds the reload directly.
                dst_x_next = '0;
                acc_load   = 1'b1;
                state_next = SCAN;
            end
            SCAN: begin
                if (handshake) begin
                    if (dst_x_reg < LAST_X) begin
                        dst_x_next = dst_x_reg + 1'b1;
                        acc_step   = 1'b1;
                    end else if (dst_y_reg < LAST_Y) begin
                        dst_y_next = dst_y_reg + 1'b1;
                        state_next = ROW_INIT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            dst_x_reg <= '0;
            dst_y_reg <= '0;
            sin_reg   <= '0;
            cos_reg   <= '0;
        end else begin
            state_reg <= state_next;
            dst_x_reg <= dst_x_next;
            dst_y_reg <= dst_y_next;
            sin_reg   <= sin_next;
            cos_reg   <= cos_next;
        end
    end

    coor_rot_acc #(
        .IMAGE_W (IMAGE_W),
        .IMAGE_H (IMAGE_H)
    ) u_rot_acc (
        .clk      (clk),
        .rst      (rst),
        .load     (acc_load),
        .step     (acc_step),
        .yc       (yc),
        .sin_lat  (sin_reg),
        .cos_lat  (cos_reg),
        .src_x    (src_x_raw),
        .src_y    (src_y_raw),
        .in_range (in_range_raw)
    );

    // Source fields read as zero outside SCAN so idle/reset state is all-zero.
    assign bus.out_valid = out_valid;
    assign bus.dst_x     = dst_x_reg;
    assign bus.dst_y     = dst_y_reg;
    assign bus.src_x     = out_valid ? src_x_raw : '0;
    assign bus.src_y     = out_valid ? src_y_raw : '0;
    assign bus.in_range  = out_valid && in_range_raw;
    assign bus.sof       = out_valid && (dst_x_reg == '0) && (dst_y_reg == '0);
    assign bus.eol       = out_valid && (dst_x_reg == LAST_X);
    assign bus.eof       = out_valid && (dst_x_reg == LAST_X) && (dst_y_reg == LAST_Y);

endmodule

// File: tb/tb_coor_trans_inverse_scan.sv
// -----------------------------------------------------------------------------
// tb_coor_trans_inverse_scan
//
// Directed bench for an 8x8 frame. Every accepted beat is compared against a
// direct-multiply model of the inverse rotation plus a table of hand-computed
// points; stalls, frame markers, done timing, busy, mid-frame start and reset
// mid-frame are exercised in one linear sequence.
// -----------------------------------------------------------------------------
module tb_coor_trans_inverse_scan;
    import coor_trans_pkg::*;

    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        int s; int c; int dx; int dy; int sx; int sy; int inr;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic signed [TRIG_W-1:0] sin_value;
    logic signed [TRIG_W-1:0] cos_value;
    logic                     busy;
    logic                     done;

    coor_trans_inverse_scan_if bus();

    coor_trans_inverse_scan #(
        .IMAGE_W (W),
        .IMAGE_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sin_value (sin_value),
        .cos_value (cos_value),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   hand_hits = 0;
    vec_t hv [8];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int dx, input int dy, input int s, input int c,
                                  output int sx, output int sy, output int inr);
        int xc, yc, ax, ay;
        xc  = dx - W / 2;
        yc  = dy - H / 2;
        ax  = xc * c + yc * s;
        ay  = yc * c - xc * s;
        sx  = (ax >>> 8) + W / 2;
        sy  = (ay >>> 8) + H / 2;
        inr = (sx >= 0 && sx < W && sy >= 0 && sy < H) ? 1 : 0;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, bus.out_valid, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_sof"},   bus.sof, 0);
        check({tag, "_eol"},   bus.eol, 0);
        check({tag, "_eof"},   bus.eof, 0);
        check({tag, "_dstx"},  bus.dst_x, 0);
        check({tag, "_dsty"},  bus.dst_y, 0);
        check({tag, "_srcx"},  bus.src_x, 0);
        check({tag, "_srcy"},  bus.src_y, 0);
        check({tag, "_inr"},   bus.in_range, 0);
    endtask

    // Runs one frame from the current negedge. restart_at / reset_at (>=0)
    // pulse start or rst once the given number of beats has been accepted.
    task automatic run_frame(input string name, input int s, input int c, input int ready_pct,
                             input int restart_at, input int reset_at,
                             output int beats, output int done_k);
        int   sofs, eofs, ex, ey, last_hs_k, msx, msy, minr;
        bit   stalled, restart_sent, hs;
        logic [COORD_W-1:0]      h_dx, h_dy;
        logic signed [ACC_W-1:0] h_sx, h_sy;
        logic                    h_inr, h_sof, h_eol, h_eof;
        sofs = 0; eofs = 0; ex = 0; ey = 0; last_hs_k = -1;
        stalled = 0; restart_sent = 0;
        h_dx = '0; h_dy = '0; h_sx = '0; h_sy = '0;
        h_inr = 0; h_sof = 0; h_eol = 0; h_eof = 0;
        beats = 0; done_k = -1;
        sin_value = TRIG_W'(s);
        cos_value = TRIG_W'(c);
        start = 1'b1;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            // Inputs wander after the start is taken; the latched angle must hold.
            sin_value = 10'sd77;
            cos_value = -10'sd99;
            start = 1'b0;
            if (reset_at >= 0 && beats == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                check_reset_state({name, "_rst"});
                rst = 1'b0;
                return;
            end
            if (restart_at >= 0 && beats == restart_at && !restart_sent) begin
                start = 1'b1;
                sin_value = 10'sd256;
                cos_value = 10'sd0;
                restart_sent = 1;
            end
            bus.out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);

            check({name, "_busy"}, busy, 1);
            check({name, "_done"}, done, (beats == W * H && last_hs_k == k - 1) ? 1 : 0);
            if (k == 1) check({name, "_rowinit_valid"}, bus.out_valid, 0);
            if (k == 2) check({name, "_first_valid"}, bus.out_valid, 1);

            if (stalled) begin
                check({name, "_hold_valid"}, bus.out_valid, 1);
                check({name, "_hold_dstx"}, bus.dst_x, h_dx);
                check({name, "_hold_dsty"}, bus.dst_y, h_dy);
                check({name, "_hold_srcx"}, bus.src_x, h_sx);
                check({name, "_hold_srcy"}, bus.src_y, h_sy);
                check({name, "_hold_inr"},  bus.in_range, h_inr);
                check({name, "_hold_sof"},  bus.sof, h_sof);
                check({name, "_hold_eol"},  bus.eol, h_eol);
                check({name, "_hold_eof"},  bus.eof, h_eof);
            end
            if (bus.out_valid) begin
                h_dx = bus.dst_x; h_dy = bus.dst_y; h_sx = bus.src_x; h_sy = bus.src_y;
                h_inr = bus.in_range; h_sof = bus.sof; h_eol = bus.eol; h_eof = bus.eof;
            end
            stalled = bus.out_valid && !bus.out_ready;
            hs = bus.out_valid && bus.out_ready;

            if (hs) begin
                model(ex, ey, s, c, msx, msy, minr);
                check({name, "_dstx"}, bus.dst_x, ex);
                check({name, "_dsty"}, bus.dst_y, ey);
                check({name, "_srcx"}, bus.src_x, msx);
                check({name, "_srcy"}, bus.src_y, msy);
                check({name, "_inr"},  bus.in_range, minr);
                check({name, "_sof"},  bus.sof, (ex == 0 && ey == 0) ? 1 : 0);
                check({name, "_eol"},  bus.eol, (ex == W - 1) ? 1 : 0);
                check({name, "_eof"},  bus.eof, (ex == W - 1 && ey == H - 1) ? 1 : 0);
                foreach (hv[i]) begin
                    if (hv[i].s == s && hv[i].c == c && hv[i].dx == ex && hv[i].dy == ey) begin
                        hand_hits++;
                        check({name, "_hand_srcx"}, bus.src_x, hv[i].sx);
                        check({name, "_hand_srcy"}, bus.src_y, hv[i].sy);
                        check({name, "_hand_inr"},  bus.in_range, hv[i].inr);
                    end
                end
                $display("%s beat %0d dst=(%0d,%0d) src=(%0d,%0d) in_range=%0d sof=%0d eol=%0d eof=%0d",
                         name, beats, bus.dst_x, bus.dst_y, bus.src_x, bus.src_y,
                         bus.in_range, bus.sof, bus.eol, bus.eof);
                if (bus.sof) sofs++;
                if (bus.eof) eofs++;
                beats++;
                last_hs_k = k;
                if (ex == W - 1) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) begin
            check({name, "_timeout"}, 0, 1);
        end
        check({name, "_beats"}, beats, W * H);
        check({name, "_sof_count"}, sofs, 1);
        check({name, "_eof_count"}, eofs, 1);
        @(negedge clk);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_done"}, done, 0);
        check({name, "_idle_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        int beats, done_k;

        // Hand-worked points: {sin, cos, dst_x, dst_y, src_x, src_y, in_range}
        hv[0] = '{0,    256, 3, 5, 3,  5, 1};
        hv[1] = '{256,  0,   0, 0, 0,  8, 0};
        hv[2] = '{256,  0,   7, 0, 0,  1, 1};
        hv[3] = '{256,  0,   0, 7, 7,  8, 0};
        hv[4] = '{0,   -256, 1, 1, 7,  7, 1};
        hv[5] = '{0,   -256, 0, 0, 8,  8, 0};
        hv[6] = '{181,  181, 0, 0, -2, 4, 0};
        hv[7] = '{181,  181, 7, 7, 8,  4, 0};

        rst = 1'b1;
        start = 1'b0;
        sin_value = '0;
        cos_value = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        run_frame("ident", 0, 256, 100, -1, -1, beats, done_k);
        check("ident_done_cycle", done_k, 73);

        run_frame("rot90", 256, 0, 100, -1, -1, beats, done_k);
        run_frame("rot180", 0, -256, 100, -1, -1, beats, done_k);
        run_frame("rot45_stall", 181, 181, 30, -1, -1, beats, done_k);

        run_frame("restart", 0, 256, 100, 10, -1, beats, done_k);
        check("restart_done_cycle", done_k, 73);

        run_frame("reset20", 181, 181, 100, -1, 20, beats, done_k);
        check("reset20_beats", beats, 20);

        run_frame("after_rst", 0, -256, 100, -1, -1, beats, done_k);
        check("after_rst_done_cycle", done_k, 73);

        check("hand_hits", hand_hits, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
